// File: rtl/reg_write_master_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : reg_write_master_if                                              |
// | Brief    : Request/response and target-register signals of reg_write_master |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface reg_write_master_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_read;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             acknowledge;
  logic             busy;
  logic [WIDTH-1:0] rd_data;

  modport master (
    input  req_valid, req_read, req_data, acknowledge, busy, rd_data,
    output req_ready, rsp_valid, rsp_err, rsp_data, wr_valid, wr_data
  );

  modport slave (
    output req_valid, req_read, req_data, acknowledge, busy, rd_data,
    input  req_ready, rsp_valid, rsp_err, rsp_data, wr_valid, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/reg_write_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : reg_write_master                                                 |
// | Brief    : Write-verify/read initiator for one target register with retries |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module reg_write_master #(
  parameter int WIDTH     = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                reset,
  reg_write_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_RWAIT = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [2:0] c_max_retry = 3'(MAX_RETRY);
  localparam logic [7:0] c_timeout   = 8'(TIMEOUT);

  state_t           r_state;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_rsp_data;
  logic [2:0]       r_retry_cnt;
  logic [7:0]       r_tmo_cnt;
  logic             r_wr_valid;
  logic             r_rsp_valid;
  logic             r_rsp_err;

  logic             w_verify_ok;
  logic             w_read_ok;

  // An unknown rd_data bit makes the equality unknown, which falls to the fail branch.
  assign w_verify_ok = bus.acknowledge && (bus.rd_data == r_shadow);
  assign w_read_ok   = bus.acknowledge && !bus.busy;

  assign bus.req_ready = (r_state == S_IDLE) && !reset;
  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_data   = r_shadow;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shadow    <= '0;
      r_rsp_data  <= '0;
      r_retry_cnt <= 3'd0;
      r_tmo_cnt   <= 8'd0;
      r_wr_valid  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_wr_valid  <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_read) begin
              r_tmo_cnt <= 8'd0;
              r_state   <= S_RWAIT;
            end else begin
              r_shadow    <= bus.req_data;
              r_retry_cnt <= 3'd0;
              r_wr_valid  <= 1'b1;
              r_state     <= S_MARK;
            end
          end
        end
        S_MARK:  r_state <= S_LOAD;
        // Target captures wr_data on the edge closing this state.
        S_LOAD:  r_state <= S_CHECK;
        S_CHECK: begin
          if (w_verify_ok) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= r_shadow;
            r_state     <= S_RESP;
          end else if (r_retry_cnt < c_max_retry) begin
            r_retry_cnt <= r_retry_cnt + 3'd1;
            r_wr_valid  <= 1'b1;
            r_state     <= S_MARK;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= bus.rd_data;
            r_state     <= S_RESP;
          end
        end
        S_RWAIT: begin
          if (w_read_ok) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= bus.rd_data;
            r_state     <= S_RESP;
          end else if (r_tmo_cnt == c_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_state     <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_reg_write_master                                              |
// | Brief    : Directed and randomized checks of reg_write_master               |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_reg_write_master;
  localparam int WIDTH     = 32;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_write_master_if #(.WIDTH(WIDTH)) bus ();

  reg_write_master #(
    .WIDTH     (WIDTH),
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Target register: loads wr_data whenever wr_valid is low; a load closing a
  // wr_valid pulse can be forced to corrupt_val to emulate a bad write.
  logic [31:0] tgt;
  logic        prev_wv = 1'b0;
  int          load_cnt = 0;
  int          corrupt_until = 0;
  logic [31:0] corrupt_val = 32'h0;
  logic        use_rd_val = 1'b0;
  logic [31:0] rd_val = 32'h0;
  int          acc_cnt = 0;

  assign bus.rd_data = use_rd_val ? rd_val : tgt;

  always @(posedge clk) begin
    if (bus.wr_valid) begin
      tgt <= $urandom;
    end else if (prev_wv) begin
      tgt      <= (load_cnt < corrupt_until) ? corrupt_val : bus.wr_data;
      load_cnt <= load_cnt + 1;
    end else begin
      tgt <= bus.wr_data;
    end
    prev_wv <= bus.wr_valid;
    if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction; stall = failed loads for a write, stalled cycles for a read.
  task automatic run_txn(input bit is_read, input logic [31:0] val, input int stall,
                         input logic [31:0] cval, input string tag);
    int          exp_lat, exp_pulses, pulses, lat;
    logic        exp_err;
    logic [31:0] exp_data;
    if (is_read) begin
      exp_pulses = 0;
      if (stall <= TIMEOUT) begin
        exp_lat = stall + 1; exp_err = 1'b0; exp_data = val;
      end else begin
        exp_lat = TIMEOUT + 1; exp_err = 1'b1; exp_data = 32'h0;
      end
    end else begin
      if (stall <= MAX_RETRY) begin
        exp_pulses = stall + 1; exp_lat = 3 + 3 * stall; exp_err = 1'b0; exp_data = val;
      end else begin
        exp_pulses = MAX_RETRY + 1; exp_lat = 3 + 3 * MAX_RETRY; exp_err = 1'b1; exp_data = cval;
      end
    end

    @(negedge clk);
    check({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
    corrupt_until   = load_cnt + (is_read ? 0 : stall);
    corrupt_val     = cval;
    use_rd_val      = is_read;
    rd_val          = val;
    bus.acknowledge = 1'b1;
    bus.busy        = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_read    = is_read;
    bus.req_data    = is_read ? ~val : val;

    lat = -1;
    pulses = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (n == 0) check({tag, ".ready_busy"}, 32'(bus.req_ready), 32'd0);
      if (bus.wr_valid) pulses++;
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      if (is_read && n < stall) begin
        case ($urandom_range(0, 2))
          0:       begin bus.acknowledge = 1'b0; bus.busy = 1'b0; end
          1:       begin bus.acknowledge = 1'b1; bus.busy = 1'b1; end
          default: begin bus.acknowledge = 1'b0; bus.busy = 1'b1; end
        endcase
      end else begin
        bus.acknowledge = 1'b1;
        bus.busy        = 1'b0;
      end
    end
    bus.acknowledge = 1'b1;
    bus.busy        = 1'b0;

    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    if (!is_read) check({tag, ".wr_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, ".rsp_data"}, bus.rsp_data, exp_data);

    @(negedge clk);
    check({tag, ".rsp_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ".rsp_data_hold"}, bus.rsp_data, exp_data);
    if (!is_read && !exp_err) check({tag, ".target_value"}, tgt, val);
  endtask

  initial begin
    int n1, n2, acc0;
    logic        seen_rsp;
    logic        rd_is;
    logic [31:0] rv;
    int          st;

    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_read    = 1'b0;
    bus.req_data    = 32'h0;
    bus.acknowledge = 1'b1;
    bus.busy        = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.req_ready", 32'(bus.req_ready), 32'd0);
    check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset.rsp_err",   32'(bus.rsp_err),   32'd0);
    check("reset.rsp_data",  bus.rsp_data,       32'h0);
    check("reset.wr_valid",  32'(bus.wr_valid),  32'd0);
    check("reset.wr_data",   bus.wr_data,        32'h0);
    reset = 1'b0;
    #1;
    check("reset.release_ready", 32'(bus.req_ready), 32'd1);

    run_txn(1'b0, 32'hA5A5_1234, 0, 32'h0, "w_ideal");
    run_txn(1'b0, 32'h1357_9BDF, 2, 32'h0, "w_retry2");
    run_txn(1'b0, 32'hDEAD_BEEF, 1000, 32'h0, "w_never");
    run_txn(1'b1, 32'h0000_00FF, 5, 32'h0, "r_busy5");
    run_txn(1'b1, 32'h7E57_0001, 20, 32'h0, "r_timeout");

    // Reset mid-write: everything clears at once and no response follows.
    @(negedge clk);
    corrupt_until = load_cnt;
    use_rd_val    = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_read  = 1'b0;
    bus.req_data  = 32'h7777_0001;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_mid.mark_wr_valid", 32'(bus.wr_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid.wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_mid.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mid.wr_data", bus.wr_data, 32'h0);
    seen_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp = 1'b1;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp = 1'b1;
    end
    check("rst_mid.no_rsp", 32'(seen_rsp), 32'd0);
    check("rst_mid.ready_after", 32'(bus.req_ready), 32'd1);
    check("rst_mid.wr_data_after", bus.wr_data, 32'h0);

    // Back-to-back: req_valid held across a write then a read.
    @(negedge clk);
    acc0          = acc_cnt;
    corrupt_until = load_cnt;
    use_rd_val    = 1'b0;
    rd_val        = 32'h0BAD_F00D;
    bus.req_valid = 1'b1;
    bus.req_read  = 1'b0;
    bus.req_data  = 32'h2468_ACE0;
    n1 = -1;
    n2 = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid && n1 < 0) begin
        n1 = n;
        check("b2b.first_data", bus.rsp_data, 32'h2468_ACE0);
        use_rd_val   = 1'b1;
        bus.req_read = 1'b1;
      end else if (bus.rsp_valid) begin
        n2 = n;
        bus.req_valid = 1'b0;
        check("b2b.second_data", bus.rsp_data, 32'h0BAD_F00D);
        break;
      end else if (n1 >= 0 && n == n1 + 1) begin
        check("b2b.idle_ready", 32'(bus.req_ready), 32'd1);
      end
    end
    bus.req_valid = 1'b0;
    check("b2b.first_lat", 32'(n1), 32'd3);
    check("b2b.second_lat", 32'(n2), 32'd6);
    repeat (3) @(negedge clk);
    check("b2b.accepts", 32'(acc_cnt - acc0), 32'd2);

    for (int i = 0; i < 24; i++) begin
      rd_is = 1'($urandom_range(0, 1));
      rv    = $urandom;
      st    = rd_is ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 5));
      run_txn(rd_is, rv, st, ~rv, $sformatf("rand%0d_%s", i, rd_is ? "rd" : "wr"));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
